// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline hazard/debug control signal bundle
//
// Groups the pipeline status inputs, the debug requests and the stall/flush
// outputs of pipe_ctrl.
//   master : pipeline side, drives ir_*, v_*, cp_ex and the debug requests,
//            and observes the stall, flush, state and counter outputs
//   slave  : pipe_ctrl itself
// Parameter CNT_W sets the stall counter width and must match pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      ir_dc;
  logic [31:0]      ir_ex;
  logic             v_dc;
  logic             v_ex;
  logic             cp_ex;
  logic             halt_req;
  logic             step_req;
  logic             resume_req;
  logic             s_fe;
  logic             s_dc;
  logic             s_ex;
  logic             s_me;
  logic             s_wb;
  logic             bubble_ex;
  logic             flush_dc;
  logic             flush_ex;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ir_dc, ir_ex, v_dc, v_ex, cp_ex, halt_req, step_req, resume_req,
    input  s_fe, s_dc, s_ex, s_me, s_wb, bubble_ex, flush_dc, flush_ex,
    input  state_o, stall_cnt
  );

  modport slave (
    input  ir_dc, ir_ex, v_dc, v_ex, cp_ex, halt_req, step_req, resume_req,
    output s_fe, s_dc, s_ex, s_me, s_wb, bubble_ex, flush_dc, flush_ex,
    output state_o, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline hazard and debug-halt controller
//
// Detects load-use hazards and taken branches between decode and execute,
// and sequences debug halt (RUN -> DRAIN -> HALT -> RUN) with an optional
// single-step state.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : pipe_ctrl_if.slave
//                in  ir_dc/ir_ex, v_dc/v_ex, cp_ex, halt_req/step_req/resume_req
//                out s_fe..s_wb, bubble_ex, flush_dc, flush_ex (combinational)
//                out state_o (RUN=0 DRAIN=1 HALT=2 STEP=3), stall_cnt (registered)
// Parameters: DRAIN_CYC (1..15) cycles spent in DRAIN, CNT_W stall counter width.
// Macro PIPE_CTRL_STEP_EN enables the single-step state; without it step_req
// is ignored and STEP is never entered.
module pipe_ctrl #(
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2,
    STEP  = 2'd3
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [3:0] DRAIN_LD   = 4'(DRAIN_CYC);

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_q;
  logic             step_prev_q;

  logic [4:0] rd_ex, rs1_dc, rs2_dc;
  logic [6:0] op_dc, op_ex;
  logic       rs1_used, rs2_used, load_use, br_taken;
  logic       stall_fire;

  // Instruction fields outside the decoded ones are not needed here.
  logic unused_bits;
  assign unused_bits = ^{bus.ir_dc[31:25], bus.ir_dc[14:7], bus.ir_ex[31:12],
                         bus.step_req};

  assign rd_ex  = bus.ir_ex[11:7];
  assign op_ex  = bus.ir_ex[6:0];
  assign rs1_dc = bus.ir_dc[19:15];
  assign rs2_dc = bus.ir_dc[24:20];
  assign op_dc  = bus.ir_dc[6:0];

  assign rs1_used = !(op_dc == OPC_LUI || op_dc == OPC_AUIPC || op_dc == OPC_JAL);
  assign rs2_used = (op_dc == OPC_BRANCH || op_dc == OPC_STORE || op_dc == OPC_OP);

  assign load_use = bus.v_ex && bus.v_dc && (op_ex == OPC_LOAD) && (rd_ex != 5'd0) &&
                    ((rs1_used && rs1_dc == rd_ex) || (rs2_used && rs2_dc == rd_ex));
  assign br_taken = bus.v_ex && bus.cp_ex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= 4'd0;
      stall_q     <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      step_prev_q <= bus.step_req;
      if (stall_fire && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    stall_fire    = 1'b0;
    bus.s_fe      = 1'b0;
    bus.s_dc      = 1'b0;
    bus.s_ex      = 1'b0;
    bus.s_me      = 1'b0;
    bus.s_wb      = 1'b0;
    bus.bubble_ex = 1'b0;
    bus.flush_dc  = 1'b0;
    bus.flush_ex  = 1'b0;

    case (state_q)
      RUN, STEP: begin
        // A taken branch discards the dependent instruction anyway, so it
        // wins over the load-use stall.
        if (br_taken) begin
          bus.flush_dc = 1'b1;
          bus.flush_ex = 1'b1;
        end else if (load_use) begin
          bus.s_fe      = 1'b1;
          bus.s_dc      = 1'b1;
          bus.bubble_ex = 1'b1;
          stall_fire    = 1'b1;
        end
        if (state_q == STEP) begin
          state_d = HALT;
        end else if (bus.halt_req) begin
          state_d = DRAIN;
          drain_d = DRAIN_LD;
        end
      end
      DRAIN: begin
        // Fetch is frozen, so a load-use stall is moot; branches still flush.
        bus.s_fe     = 1'b1;
        bus.flush_dc = 1'b1;
        bus.flush_ex = br_taken;
        if (drain_q <= 4'd1) begin
          state_d = HALT;
          drain_d = 4'd0;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: begin // HALT
        bus.s_fe = 1'b1;
        bus.s_dc = 1'b1;
        bus.s_ex = 1'b1;
        bus.s_me = 1'b1;
        bus.s_wb = 1'b1;
        if (bus.resume_req) begin
          state_d = RUN;
        end
`ifdef PIPE_CTRL_STEP_EN
        // Only a fresh rising edge of step_req takes a step.
        else if (bus.step_req && !step_prev_q) begin
          state_d = STEP;
        end
`endif
      end
    endcase

    if (rst) begin
      stall_fire    = 1'b0;
      bus.s_fe      = 1'b1;
      bus.s_dc      = 1'b1;
      bus.s_ex      = 1'b1;
      bus.s_me      = 1'b1;
      bus.s_wb      = 1'b1;
      bus.bubble_ex = 1'b0;
      bus.flush_dc  = 1'b0;
      bus.flush_ex  = 1'b0;
    end
  end

  assign bus.state_o   = state_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  localparam int DRAIN_CYC = 4;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef PIPE_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_STEP = 3;

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_655 = 32'h00228333;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_600 = 32'h00000333;
  localparam logic [31:0] LUI_X5  = 32'h000012B7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  int m_state;
  int m_left;
  int m_cnt;
  bit m_step_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads_reg(input logic [31:0] ir, input int r);
    int op  = int'(ir & 32'h7f);
    int rs1 = int'((ir >> 15) & 32'h1f);
    int rs2 = int'((ir >> 20) & 32'h1f);
    bit u1  = !(op == 'h37 || op == 'h17 || op == 'h6f);
    bit u2  = (op == 'h63 || op == 'h23 || op == 'h33);
    return (u1 && rs1 == r) || (u2 && rs2 == r);
  endfunction

  function automatic bit m_load_use();
    int rd = int'((bus.ir_ex >> 7) & 32'h1f);
    return bus.v_ex && bus.v_dc && ((bus.ir_ex & 32'h7f) == 32'h03) && rd != 0 &&
           reads_reg(bus.ir_dc, rd);
  endfunction

  // {s_fe,s_dc,s_ex,s_me,s_wb,bubble_ex,flush_dc,flush_ex}
  function automatic logic [7:0] m_outputs();
    bit br = bus.v_ex && bus.cp_ex;
    if (rst) return 8'b11111_000;
    if (m_state == M_RUN || m_state == M_STEP) begin
      if (br) return 8'b00000_011;
      if (m_load_use()) return 8'b11000_100;
      return 8'b00000_000;
    end
    if (m_state == M_DRAIN) return {1'b1, 4'b0000, 1'b0, 1'b1, br};
    return 8'b11111_000;
  endfunction

  task automatic m_reset();
    m_state = M_RUN; m_left = 0; m_cnt = 0; m_step_prev = 1'b0;
  endtask

  task automatic m_advance();
    bit br = bus.v_ex && bus.cp_ex;
    bit sp = m_step_prev;
    m_step_prev = bus.step_req;
    if ((m_state == M_RUN || m_state == M_STEP) && !br && m_load_use())
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    case (m_state)
      M_RUN:   if (bus.halt_req) begin m_state = M_DRAIN; m_left = DRAIN_CYC; end
      M_DRAIN: begin m_left--; if (m_left == 0) m_state = M_HALT; end
      M_HALT:  if (bus.resume_req) m_state = M_RUN;
               else if (STEP_EN && bus.step_req && !sp) m_state = M_STEP;
      default: m_state = M_HALT;
    endcase
  endtask

  // Check mid-cycle, then advance the model with the DUT at the rising edge.
  task automatic cycle();
    @(negedge clk);
    chk("ctl", {24'd0, bus.s_fe, bus.s_dc, bus.s_ex, bus.s_me, bus.s_wb,
                bus.bubble_ex, bus.flush_dc, bus.flush_ex}, {24'd0, m_outputs()});
    chk("state", {30'd0, bus.state_o}, m_state);
    chk("cnt", {28'd0, bus.stall_cnt}, m_cnt);
    @(posedge clk);
    if (rst) m_reset(); else m_advance();
    #1;
  endtask

  task automatic drive(input logic [31:0] idc, input logic [31:0] iex, input bit vdc,
                       input bit vex, input bit cp, input bit h, input bit s, input bit r);
    bus.ir_dc = idc; bus.ir_ex = iex; bus.v_dc = vdc; bus.v_ex = vex; bus.cp_ex = cp;
    bus.halt_req = h; bus.step_req = s; bus.resume_req = r;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] ops [8] = '{7'h03, 7'h37, 7'h17, 7'h6f, 7'h63, 7'h23, 7'h33, 7'h13};
    logic [31:0] ir = $urandom;
    ir[6:0]   = ops[$urandom_range(0, 7)];
    ir[11:7]  = 5'($urandom_range(0, 3));
    ir[19:15] = 5'($urandom_range(0, 3));
    ir[24:20] = 5'($urandom_range(0, 3));
    return ir;
  endfunction

  int cnt_seen;
  int guard;

  initial begin
    m_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Load-use: one stall cycle, counter becomes 1.
    drive(ADD_655, LW_X5, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_sfe", {31'd0, bus.s_fe}, 1);
    chk("lu_bub", {31'd0, bus.bubble_ex}, 1);
    @(posedge clk); m_advance(); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("lu_cnt1", {28'd0, bus.stall_cnt}, 1);

    // No false hazards.
    drive(ADD_600, LW_X0, 1, 1, 0, 0, 0, 0);
    cycle();
    drive(LUI_X5, LW_X5, 1, 1, 0, 0, 0, 0);
    cycle();
    chk("nofalse_cnt", {28'd0, bus.stall_cnt}, 1);

    // Branch beats load-use.
    drive(ADD_655, LW_X5, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("br_fdc", {31'd0, bus.flush_dc}, 1);
    chk("br_sfe", {31'd0, bus.s_fe}, 0);
    @(posedge clk); m_advance(); #1;
    chk("br_cnt", {28'd0, bus.stall_cnt}, 1);

    // Halt: DRAIN for DRAIN_CYC cycles, then HALT, then resume.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cnt_seen = 0;
    guard = 0;
    while (bus.state_o == 2'd1 && guard < 20) begin
      cnt_seen++; guard++;
      cycle();
    end
    chk("drain_len", cnt_seen, DRAIN_CYC);
    chk("halted", {30'd0, bus.state_o}, 2);
    cycle();

    // Step request held for three cycles.
    cnt_seen = 0;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      if (bus.state_o == 2'd3) cnt_seen++;
      cycle();
    end
    if (bus.state_o == 2'd3) cnt_seen++;
    chk("step_cnt", cnt_seen, STEP_EN ? 1 : 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("resumed", {30'd0, bus.state_o}, 0);

    // Counter saturation.
    drive(ADD_655, LW_X5, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < CNT_MAX + 4; i++) cycle();
    chk("sat", {28'd0, bus.stall_cnt}, CNT_MAX);

    // Asynchronous reset in the middle of DRAIN.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_state", {30'd0, bus.state_o}, 0);
    chk("arst_stall", {27'd0, bus.s_fe, bus.s_dc, bus.s_ex, bus.s_me, bus.s_wb}, 5'h1f);
    chk("arst_cnt", {28'd0, bus.stall_cnt}, 0);
    m_reset();
    cycle();
    rst = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(rand_ir(), rand_ir(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYC, default 4, meaning the number of cycles spent in DRAIN before HALT (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-003 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have ir_dc and ir_ex, inputs, 32 each, the instructions held in decode and execute.
REQ-006 SHALL have v_dc, v_ex, and cp_ex, inputs, 1 each: decode valid, execute valid, and branch/jump taken in execute.
REQ-007 SHALL have halt_req, step_req, and resume_req, inputs, 1 each, the debug requests; all are level-sampled.
REQ-008 SHALL have s_fe, s_dc, s_ex, s_me, and s_wb, outputs, 1 each, the per-stage stalls; 1 means the stage holds.
REQ-009 SHALL have bubble_ex, flush_dc, and flush_ex, outputs, 1 each: insert a NOP into execute, and invalidate decode or execute contents.
REQ-010 SHALL have state_o, output, 2, the FSM state: RUN=0, DRAIN=1, HALT=2, STEP=3.
REQ-011 SHALL have stall_cnt, output, CNT_W, the count of load-use stall cycles.

Function
REQ-012 SHALL make all stall, bubble, and flush outputs combinational from the registered state and the current inputs; state_o and stall_cnt SHALL be registered.
REQ-013 SHALL define rd_ex as ir_ex[11:7], rs1_dc as ir_dc[19:15], and rs2_dc as ir_dc[24:20].
REQ-014 SHALL treat rs1 as used unless the ir_dc opcode is LUI, AUIPC, or JAL.
REQ-015 SHALL treat rs2 as used only for opcodes BRANCH, STORE, and OP.
REQ-016 SHALL define load_use as: v_ex, v_dc, ir_ex opcode 0000011, rd_ex != 0, and a used rs equal to rd_ex.
REQ-017 SHALL define br_taken as v_ex & cp_ex.
REQ-018 SHALL, in RUN with br_taken, assert flush_dc=1 and flush_ex=1 for that cycle, with all s_*=0.
REQ-019 SHALL, in RUN with load_use and not br_taken, assert s_fe=1, s_dc=1, and bubble_ex=1 for that cycle, with s_ex=s_me=s_wb=0.
REQ-020 SHALL give br_taken priority over load_use when both occur in the same cycle; no stall occurs and stall_cnt is not incremented.
REQ-021 SHALL make the load-use stall last exactly one cycle per hazard; after the bubble, the load sits in memory and forwarding resolves the dependency.
REQ-022 SHALL increment stall_cnt by one on each cycle in which REQ-019 applies.
REQ-023 SHALL saturate stall_cnt at all-ones, with no wrap-around.
REQ-024 SHALL transition RUN to DRAIN when halt_req=1.
REQ-025 SHALL, in DRAIN, assert s_fe=1 and flush_dc=1 while the remaining stages run for DRAIN_CYC cycles, counted by an internal down-counter; the state SHALL then become HALT.
REQ-026 SHALL, in DRAIN, still honour br_taken flushes while not honouring load-use stalls, since fetch is already frozen.
REQ-027 SHALL, in HALT, assert all s_*=1 and all flush and bubble outputs =0.
REQ-028 SHALL transition HALT to RUN on resume_req=1.
REQ-029 SHALL ignore halt_req while in DRAIN or HALT.
REQ-030 SHALL give resume_req priority over step_req when both are asserted together in HALT.

Reset
REQ-031 SHALL, while rst=1, assert all s_*=1 and hold flush_dc, flush_ex, and bubble_ex at 0.
REQ-032 SHALL, while rst=1, set state_o=RUN, stall_cnt=0, and the drain counter=0, immediately and without waiting for clk.
REQ-033 SHALL abort any DRAIN, HALT, or STEP on reset asserted mid-operation, and SHALL resume in RUN on the first edge after release.

Configuration
REQ-034 SHALL include single-step support only when the macro PIPE_CTRL_STEP_EN is defined.
REQ-035 SHALL, with PIPE_CTRL_STEP_EN defined, transition HALT to STEP on step_req=1 (when resume_req=0), drive all s_*=0 with hazard rules applied for exactly one cycle in STEP, then return to HALT.
REQ-036 SHALL, with PIPE_CTRL_STEP_EN defined, require step_req to be deasserted for at least one cycle before another step is taken, detected as a rising edge.
REQ-037 SHALL, without PIPE_CTRL_STEP_EN, ignore step_req, and state_o SHALL never equal 3.

Verification
REQ-038 SHALL cover load-use: ir_ex=lw x5,0(x1) with v_ex=1, and ir_dc=add x6,x5,x2 with v_dc=1 -> one cycle of s_fe=s_dc=1 and bubble_ex=1, then stall_cnt=1.
REQ-039 SHALL cover no false hazard: ir_ex=lw x0,0(x1) with ir_dc=add x6,x0,x0, and separately a load to x5 with ir_dc=lui x5,1 -> no stall and stall_cnt=0.
REQ-040 SHALL cover simultaneous events: cp_ex=1 with a load-use pattern present -> flush_dc=flush_ex=1, s_fe=0, and stall_cnt unchanged.
REQ-041 SHALL cover halt: halt_req pulse in RUN with DRAIN_CYC=4 -> state_o=1 for 4 cycles with s_fe=1, then state_o=2 with all s_*=1; resume_req -> state_o=0.
REQ-042 SHALL cover single-step with PIPE_CTRL_STEP_EN defined: in HALT, hold step_req high for 3 cycles -> exactly one cycle with state_o=3 and s_*=0; without the macro -> state_o stays 2.
REQ-043 SHALL cover reset mid-operation: rst asserted during DRAIN -> state_o=0 and all s_*=1 asynchronously, and stall_cnt=0.
